// File: rtl/ofdm_rate_pkg.sv
// Shared types and rate tables for the OFDM symbol tracker: FSM encodings and
// the data-bits-per-symbol lookup for legacy and HT (1-2 stream) rates.
package ofdm_rate_pkg;

   localparam int unsigned DBPS_W = 10;

   localparam logic [3:0] RATE_6M  = 4'hB;
   localparam logic [3:0] RATE_9M  = 4'hF;
   localparam logic [3:0] RATE_12M = 4'hA;
   localparam logic [3:0] RATE_18M = 4'hE;
   localparam logic [3:0] RATE_24M = 4'h9;
   localparam logic [3:0] RATE_36M = 4'hD;
   localparam logic [3:0] RATE_48M = 4'h8;
   localparam logic [3:0] RATE_54M = 4'hC;

   typedef enum logic [2:0] {StIdle, StCalc, StFix, StTrack, StDone} trk_state_e;
   typedef enum logic [1:0] {DivIdle, DivRun, DivFix} div_phase_e;

   // Returns 0 for any rate this receiver cannot decode.
   function automatic logic [DBPS_W-1:0] n_dbps_lookup(input logic [7:0] rate,
                                                       input int unsigned max_nss);
      logic [DBPS_W-1:0] n;
      n = '0;
      if (rate[7]) begin
         if (rate[6:4] == 3'd0 && 32'(rate[3:0]) < 8 * max_nss) begin
            case (rate[3:0])
               4'd0:  n = 10'd26;
               4'd1:  n = 10'd52;
               4'd2:  n = 10'd78;
               4'd3:  n = 10'd104;
               4'd4:  n = 10'd156;
               4'd5:  n = 10'd208;
               4'd6:  n = 10'd234;
               4'd7:  n = 10'd260;
               4'd8:  n = 10'd52;
               4'd9:  n = 10'd104;
               4'd10: n = 10'd156;
               4'd11: n = 10'd208;
               4'd12: n = 10'd312;
               4'd13: n = 10'd416;
               4'd14: n = 10'd468;
               default: n = 10'd520;
            endcase
         end
      end else begin
         case (rate[3:0])
            RATE_6M:  n = 10'd24;
            RATE_9M:  n = 10'd36;
            RATE_12M: n = 10'd48;
            RATE_18M: n = 10'd72;
            RATE_24M: n = 10'd96;
            RATE_36M: n = 10'd144;
            RATE_48M: n = 10'd192;
            RATE_54M: n = 10'd216;
            default:  n = '0;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/ceil_div_serial.sv
// Restoring serial divider returning ceil(dividend / divisor): one quotient bit
// per cycle, then a single fix-up cycle during which done and quotient are valid.
module ceil_div_serial
   import ofdm_rate_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = 20,
   parameter int unsigned DIVISOR_W  = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  step_last,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W);

   div_phase_e            phase_q, phase_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] quo_q, quo_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
   logic [DIVISOR_W:0]    trial, diff;
   logic                  fits;

   // quo_q doubles as the dividend shift register: dividend bits leave at the
   // top while quotient bits enter at the bottom.
   assign trial = {rem_q, quo_q[DIVIDEND_W-1]};
   assign diff  = trial - {1'b0, dsr_q};
   assign fits  = trial >= {1'b0, dsr_q};

   assign step_last = (phase_q == DivRun) && (cnt_q == CNT_W'(DIVIDEND_W - 1));
   assign done      = (phase_q == DivFix);
   assign quotient  = quo_q + DIVIDEND_W'(rem_q != '0);

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dsr_d   = dsr_q;
      if (start) begin
         phase_d = DivRun;
         cnt_d   = '0;
         quo_d   = dividend;
         rem_d   = '0;
         dsr_d   = divisor;
      end else begin
         unique case (phase_q)
            DivRun: begin
               rem_d = fits ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
               quo_d = {quo_q[DIVIDEND_W-2:0], fits};
               cnt_d = cnt_q + CNT_W'(1);
               if (step_last) phase_d = DivFix;
            end
            DivFix:  phase_d = DivIdle;
            default: phase_d = DivIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= DivIdle;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dsr_q   <= '0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dsr_q   <= dsr_d;
      end
   end

endmodule

// File: rtl/ofdm_sym_tracker.sv
// OFDM RX symbol tracker: computes N_SYM from rate and PSDU length, counts decoded
// symbols, flags the last symbols ahead of time and reports completion.
module ofdm_sym_tracker
   import ofdm_rate_pkg::*;
#(
   parameter int unsigned LEN_WIDTH = 16,
   parameter int unsigned SYM_WIDTH = 12,
   parameter int unsigned MAX_NSS   = 2,
   parameter int unsigned LOOKAHEAD = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [7:0]           pkt_rate,
   input  logic [LEN_WIDTH-1:0] pkt_len,
   input  logic                 sym_valid,
   output logic                 busy,
   output logic [SYM_WIDTH-1:0] n_sym,
   output logic                 n_sym_valid,
   output logic [SYM_WIDTH-1:0] sym_idx,
   output logic                 last_sym_flag,
   output logic                 all_sym_done,
   output logic                 rate_err,
   output logic                 len_err
);

   localparam int unsigned DIV_W = LEN_WIDTH + 4;

   trk_state_e           state_q, state_d;
   logic [SYM_WIDTH-1:0] n_sym_q, n_sym_d, sym_idx_q, sym_idx_d, sym_idx_inc;
   logic                 nsv_q, nsv_d, done_q, done_d;
   logic                 rate_err_q, rate_err_d, len_err_q, len_err_d;
   logic [DBPS_W-1:0]    start_dbps;
   logic                 rate_ok;
   logic [DIV_W-1:0]     n_bit, div_q;
   logic                 div_step_last, div_done, div_ovf;
   logic [SYM_WIDTH:0]   remaining;

   assign start_dbps = n_dbps_lookup(pkt_rate, MAX_NSS);
   assign rate_ok    = start_dbps != '0;
   // 16 service bits + 6 tail bits on top of the PSDU.
   assign n_bit      = DIV_W'({pkt_len, 3'b000}) + DIV_W'(22);

   ceil_div_serial #(
      .DIVIDEND_W(DIV_W),
      .DIVISOR_W (DBPS_W)
   ) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (start && rate_ok),
      .dividend (n_bit),
      .divisor  (start_dbps),
      .step_last(div_step_last),
      .done     (div_done),
      .quotient (div_q)
   );

   assign div_ovf     = (div_q >> SYM_WIDTH) != '0;
   assign sym_idx_inc = (sym_idx_q == '1) ? sym_idx_q : sym_idx_q + SYM_WIDTH'(1);

   always_comb begin
      state_d    = state_q;
      n_sym_d    = n_sym_q;
      sym_idx_d  = sym_idx_q;
      nsv_d      = 1'b0;
      done_d     = 1'b0;
      rate_err_d = rate_err_q;
      len_err_d  = len_err_q;
      if (start) begin
         state_d    = rate_ok ? StCalc : StIdle;
         n_sym_d    = '0;
         sym_idx_d  = '0;
         rate_err_d = !rate_ok;
         len_err_d  = 1'b0;
      end else begin
         if (sym_valid && (state_q inside {StCalc, StFix, StTrack})) sym_idx_d = sym_idx_inc;
         unique case (state_q)
            StCalc: if (div_step_last) state_d = StFix;
            StFix: begin
               if (div_done) begin
                  if (div_ovf) begin
                     len_err_d = 1'b1;
                     state_d   = StIdle;
                  end else begin
                     n_sym_d = SYM_WIDTH'(div_q);
                     nsv_d   = 1'b1;
                     state_d = StTrack;
                  end
               end
            end
            // Symbols that arrived during CALC/FIX may already cover the packet.
            StTrack: begin
               if (sym_idx_d >= n_sym_q) begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         n_sym_q    <= '0;
         sym_idx_q  <= '0;
         nsv_q      <= 1'b0;
         done_q     <= 1'b0;
         rate_err_q <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_sym_q    <= n_sym_d;
         sym_idx_q  <= sym_idx_d;
         nsv_q      <= nsv_d;
         done_q     <= done_d;
         rate_err_q <= rate_err_d;
         len_err_q  <= len_err_d;
      end
   end

   // Extra bit: a negative result (overrun) reads as "last symbol reached".
   assign remaining     = {1'b0, n_sym_q} - {1'b0, sym_idx_q};
   assign last_sym_flag = ((state_q == StTrack) || (state_q == StDone)) &&
                          (remaining[SYM_WIDTH] || (remaining <= (SYM_WIDTH + 1)'(LOOKAHEAD)));

   assign busy         = state_q != StIdle;
   assign n_sym        = n_sym_q;
   assign n_sym_valid  = nsv_q;
   assign sym_idx      = sym_idx_q;
   assign all_sym_done = done_q;
   assign rate_err     = rate_err_q;
   assign len_err      = len_err_q;

endmodule
